// File: rtl/cache_tag_array_sa_pkg.sv
// Shared types for the set-associative tag store: entry layout and controller states.
package cache_def;

  // Entry tag width; the tag array's TAG_W parameter must equal this.
  localparam int ENTRY_TAG_W = 18;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [ENTRY_TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {INIT, IDLE, FLUSH} tag_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim selection and next-state bits after touching a way.
// Node n has children 2n+1 (left) and 2n+2 (right); a node bit names the side holding the victim.
module plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  bits_next
);

  always_comb begin
    int vnode;
    victim = '0;
    vnode  = 0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = bits[vnode];
      vnode = 2*vnode + 1 + int'(bits[vnode]);
    end
  end

  // Touching a way points every node on its path at the opposite subtree.
  always_comb begin
    int tnode;
    bits_next = bits;
    tnode     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      bits_next[tnode] = ~touch_way[WAY_W-1-l];
      tnode = 2*tnode + 1 + int'(touch_way[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/cache_tag_array_sa.sv
// N-way set-associative tag store with per-set tree-PLRU, registered lookup and self-clearing sweep.
// Optional feature: define TAG_PARITY_EN for per-entry even parity and the rsp_perr output.
module cache_tag_array_sa import cache_def::*; #(
  parameter  int SETS    = 1024,
  parameter  int WAYS    = 4,
  parameter  int TAG_W   = ENTRY_TAG_W,
  localparam int INDEX_W = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [WAY_W-1:0]   rsp_way,
  output logic               rsp_victim_valid,
  output logic               rsp_victim_dirty,
  output logic [TAG_W-1:0]   rsp_victim_tag,
`ifdef TAG_PARITY_EN
  output logic               rsp_perr,
`endif
  input  logic               upd_we,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [WAY_W-1:0]   upd_way,
  input  tag_entry_t         upd_entry,
  input  logic               flush_start,
  output logic               flush_busy,
  output logic               flush_done
);

  tag_entry_t         tags [SETS][WAYS];
  logic [WAYS-2:0]    plru [SETS];
`ifdef TAG_PARITY_EN
  logic               par  [SETS][WAYS];
`endif

  tag_state_e         state, state_nxt;
  logic [INDEX_W-1:0] cnt;
  logic               sweeping, sweep_last, accept, upd_go, hit;
  logic [WAYS-1:0]    match, inval, perr_way;
  logic [WAY_W-1:0]   hit_way, free_way, plru_victim, miss_way;
  logic [WAYS-2:0]    look_next, upd_base, upd_next;
  logic [WAY_W-1:0]   upd_victim_unused;
  tag_entry_t         victim_e;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    flush_busy = 1'b1;
    case (state)
      INIT, FLUSH: if (sweep_last) state_nxt = IDLE;
      IDLE: begin
        req_ready  = 1'b1;
        flush_busy = 1'b0;
        if (flush_start) state_nxt = FLUSH;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign sweeping   = (state != IDLE);
  assign sweep_last = (cnt == INDEX_W'(SETS-1));
  assign accept     = req_valid && (state == IDLE) && !flush_start;
  assign upd_go     = upd_we && (state == IDLE);

  // ---------------- lookup ----------------
  always_comb begin
    match    = '0;
    inval    = '0;
    perr_way = '0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef TAG_PARITY_EN
      perr_way[w] = ^{par[req_index][w], tags[req_index][w]};
`endif
      inval[w] = !tags[req_index][w].valid;
      match[w] = tags[req_index][w].valid && (tags[req_index][w].tag == req_tag) && !perr_way[w];
    end
  end

  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (match[w]) hit_way  = WAY_W'(w);
      if (inval[w]) free_way = WAY_W'(w);
    end
  end

  assign hit      = |match;
  assign miss_way = (|inval) ? free_way : plru_victim;
  assign victim_e = tags[req_index][miss_way];

  plru_tree #(.WAYS(WAYS)) u_plru_look (
    .bits      (plru[req_index]),
    .touch_way (hit_way),
    .victim    (plru_victim),
    .bits_next (look_next)
  );

  // A same-set hit touch is folded in first so the update touch lands on top of it.
  assign upd_base = (accept && hit && (upd_index == req_index)) ? look_next : plru[upd_index];

  plru_tree #(.WAYS(WAYS)) u_plru_upd (
    .bits      (upd_base),
    .touch_way (upd_way),
    .victim    (upd_victim_unused),
    .bits_next (upd_next)
  );

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweeping) begin
        for (int w = 0; w < WAYS; w++) begin
          tags[cnt][w] <= '0;
`ifdef TAG_PARITY_EN
          par[cnt][w]  <= 1'b0;
`endif
        end
        plru[cnt] <= '0;
      end else begin
        if (accept && hit) plru[req_index] <= look_next;
        if (upd_go) begin
          tags[upd_index][upd_way] <= upd_entry;
`ifdef TAG_PARITY_EN
          par[upd_index][upd_way]  <= ^upd_entry;
`endif
          plru[upd_index] <= upd_next;
        end
      end
    end
  end

  // ---------------- sweep counter and response registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt              <= '0;
      flush_done       <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_way          <= '0;
      rsp_victim_valid <= 1'b0;
      rsp_victim_dirty <= 1'b0;
      rsp_victim_tag   <= '0;
`ifdef TAG_PARITY_EN
      rsp_perr         <= 1'b0;
`endif
    end else begin
      cnt              <= sweeping ? cnt + 1'b1 : '0;
      flush_done       <= sweeping && sweep_last;
      rsp_valid        <= accept;
      rsp_hit          <= accept && hit;
      rsp_way          <= !accept ? '0 : (hit ? hit_way : miss_way);
      rsp_victim_valid <= accept && !hit && victim_e.valid;
      rsp_victim_dirty <= accept && !hit && victim_e.dirty;
      rsp_victim_tag   <= (accept && !hit) ? victim_e.tag : '0;
`ifdef TAG_PARITY_EN
      rsp_perr         <= accept && (|perr_way);
`endif
    end
  end

  // Software must never store the same valid tag twice in one set.
  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) accept |-> $onehot0(match));

endmodule

// File: tb/tb_cache_tag_array_sa.sv
// Randomized bench for cache_tag_array_sa against a per-set behavioural model (tags + MRU-side tree).
module tb_cache_tag_array_sa;
  import cache_def::*;

  localparam int SETS = 1024;
  localparam int WAYS = 4;
  localparam int IW   = 10;
  localparam int WW   = 2;
  localparam int TW   = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [IW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_hit, rsp_victim_valid, rsp_victim_dirty;
  logic [WW-1:0] rsp_way;
  logic [TW-1:0] rsp_victim_tag;
  logic          upd_we;
  logic [IW-1:0] upd_index;
  logic [WW-1:0] upd_way;
  tag_entry_t    upd_entry;
  logic          flush_start, flush_busy, flush_done;
`ifdef TAG_PARITY_EN
  logic          rsp_perr;
`endif

  always #5 clk = ~clk;

  cache_tag_array_sa dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_victim_valid(rsp_victim_valid), .rsp_victim_dirty(rsp_victim_dirty),
    .rsp_victim_tag(rsp_victim_tag),
`ifdef TAG_PARITY_EN
    .rsp_perr(rsp_perr),
`endif
    .upd_we(upd_we), .upd_index(upd_index), .upd_way(upd_way), .upd_entry(upd_entry),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_v   [SETS][WAYS];
  bit m_d   [SETS][WAYS];
  int m_t   [SETS][WAYS];
  bit m_mru [SETS][WAYS-1];   // per tree node: side (0 left / 1 right) touched most recently

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin m_v[s][w] = 0; m_d[s][w] = 0; m_t[s][w] = 0; end
      for (int n = 0; n < WAYS-1; n++) m_mru[s][n] = 0;
    end
  endfunction

  function automatic void m_touch(input int s, input int way);
    int lo = 0, n = WAYS;
    while (n > 1) begin
      int half = n / 2;
      int node = WAYS / n - 1 + lo / n;
      bit side = (way >= lo + half);
      m_mru[s][node] = side;
      if (side) lo += half;
      n = half;
    end
  endfunction

  function automatic int m_victim(input int s);
    int lo = 0, n = WAYS;
    while (n > 1) begin
      int half = n / 2;
      int node = WAYS / n - 1 + lo / n;
      if (!m_mru[s][node]) lo += half;
      n = half;
    end
    return lo;
  endfunction

  function automatic void m_look(input int s, input int t, output bit h, output int w,
                                 output bit vv, output bit vd, output int vt);
    w = -1; h = 0; vv = 0; vd = 0; vt = 0;
    for (int i = 0; i < WAYS; i++) if (w < 0 && m_v[s][i] && m_t[s][i] == t) w = i;
    if (w >= 0) begin h = 1; return; end
    for (int i = 0; i < WAYS; i++) if (w < 0 && !m_v[s][i]) w = i;
    if (w < 0) w = m_victim(s);
    vv = m_v[s][w]; vd = m_d[s][w]; vt = m_t[s][w];
  endfunction

  // One IDLE-state cycle: drive at negedge, check the response one negedge later, then advance the model.
  task automatic step(input bit rv, input int idx, input int tg,
                      input bit uw, input int uidx, input int uway, input bit uv, input bit ud, input int utg,
                      input bit fl);
    bit acc, eh, evv, evd;
    int ew, evt;
    acc = rv && !fl;
    if (acc) m_look(idx, tg, eh, ew, evv, evd, evt);
    req_valid = rv; req_index = IW'(idx); req_tag = TW'(tg);
    upd_we = uw; upd_index = IW'(uidx); upd_way = WW'(uway);
    upd_entry = '{valid: uv, dirty: ud, tag: TW'(utg)};
    flush_start = fl;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(acc));
    if (acc) begin
      chk("rsp_hit", 32'(rsp_hit), 32'(eh));
      chk("rsp_way", 32'(rsp_way), 32'(ew));
      chk("victim_valid", 32'(rsp_victim_valid), 32'(evv));
      chk("victim_dirty", 32'(rsp_victim_dirty), 32'(evd));
      chk("victim_tag", 32'(rsp_victim_tag), 32'(evt));
      if (eh) m_touch(idx, ew);
    end
    if (uw) begin
      m_v[uidx][uway] = uv; m_d[uidx][uway] = ud; m_t[uidx][uway] = utg;
      m_touch(uidx, uway);
    end
    req_valid = 0; upd_we = 0; flush_start = 0;
  endtask

  task automatic look(input int idx, input int tg);
    step(1, idx, tg, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int idx, input int way, input bit v, input bit d, input int tg);
    step(0, 0, 0, 1, idx, way, v, d, tg, 0);
  endtask

  // Wait out a sweep while hammering requests/updates that must be ignored.
  task automatic wait_sweep(input string nm);
    int n = 0;
    bit saw_rsp = 0;
    req_valid = 1; req_index = 5; req_tag = 3;
    upd_we = 1; upd_index = 5; upd_way = 3; upd_entry = '{valid: 1, dirty: 1, tag: 3};
    while (flush_busy && n < 3000) begin
      n++;
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    req_valid = 0; upd_we = 0;
    chk({nm, "_cycles"}, 32'(n), 32'd1024);
    chk({nm, "_ignored"}, 32'(saw_rsp), 32'd0);
    chk({nm, "_done"}, 32'(flush_done), 32'd1);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    m_clear();
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(flush_done), 32'd0);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_index = 0; req_tag = 0;
    upd_we = 0; upd_index = 0; upd_way = 0; upd_entry = '0; flush_start = 0;
    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(flush_busy), 1);
    chk("rst_done", 32'(flush_done), 0);
    rst_n = 1;
    wait_sweep("init");

    // basic miss / install / hit
    look(5, 'h3);
    upd(5, 2, 1, 0, 'h3);
    look(5, 'h3);
    chk("hit_way2", 32'(rsp_way), 2);
    look(5, 'h4);

    // PLRU: fill set 7, touch ways 1 and 3, expect way 0 as victim
    for (int w = 0; w < WAYS; w++) upd(7, w, 1, 0, 'h10 + w);
    look(7, 'h11);
    look(7, 'h13);
    look(7, 'h20);
    chk("plru_victim", 32'(rsp_way), 0);
    chk("plru_vtag", 32'(rsp_victim_tag), 'h10);

    // read-before-write on the same set
    step(1, 9, 'hA, 1, 9, 0, 1, 0, 'hA, 0);
    chk("rbw_miss", 32'(rsp_hit), 0);
    look(9, 'hA);
    chk("rbw_hit", 32'(rsp_hit), 1);

    // random traffic on a small window of sets
    for (int i = 0; i < 1500; i++) begin
      bit rv, uw, uv, ud;
      int idx, tg, uidx, uway, utg;
      rv = ($urandom_range(3) != 0);
      idx = 16 + $urandom_range(7);
      tg = $urandom_range(5);
      uw = ($urandom_range(2) == 0);
      uidx = ($urandom_range(3) == 0) ? idx : 16 + $urandom_range(7);
      uway = $urandom_range(WAYS-1);
      uv = ($urandom_range(3) != 0);
      ud = $urandom_range(1);
      utg = $urandom_range(5);
      for (int w = 0; w < WAYS; w++)
        if (w != uway && m_v[uidx][w] && m_t[uidx][w] == utg) uv = 0;
      step(rv, idx, tg, uw, uidx, uway, uv, ud, utg, 0);
    end

    // dirty entries, then flush colliding with a request
    upd(5, 1, 1, 1, 'h7);
    upd(7, 2, 1, 1, 'h12);
    step(1, 5, 'h7, 0, 0, 0, 0, 0, 0, 1);
    wait_sweep("flush");
    for (int i = 0; i < 24; i++) begin
      look($urandom_range(31), $urandom_range(31));
      chk("post_flush_hit", 32'(rsp_hit), 0);
      chk("post_flush_dirty", 32'(rsp_victim_dirty), 0);
    end

`ifdef TAG_PARITY_EN
    upd(3, 1, 1, 0, 'h5);
    dut.tags[3][1].tag[0] = ~dut.tags[3][1].tag[0];
    req_valid = 1; req_index = 3; req_tag = 'h5;
    @(negedge clk);
    req_valid = 0;
    chk("perr_flag", 32'(rsp_perr), 1);
    chk("perr_nohit", 32'(rsp_hit), 0);
    dut.tags[3][1].tag[0] = ~dut.tags[3][1].tag[0];
    look(3, 'h5);
    chk("perr_clear", 32'(rsp_perr), 0);
`endif

    // reset with a request in flight drops the response; reset mid-sweep restarts it
    req_valid = 1; req_index = 5; req_tag = 'h7; rst_n = 0;
    @(negedge clk);
    req_valid = 0;
    chk("rst_drop_rsp", 32'(rsp_valid), 0);
    chk("rst_busy2", 32'(flush_busy), 1);
    rst_n = 1;
    repeat (100) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    wait_sweep("restart");
    look(7, 'h11);
    chk("restart_miss", 32'(rsp_hit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
